onchip_mem_ctrl: RTL and testbench

- Synthesizable, parametrised single-port on-chip RAM with controller logic, for use by the lab CPU datapath.
- Generalises the simulation-only test memory in three ways:
  - configurable data/address width and depth;
  - per-byte write enables and a configurable read latency with a valid strobe;
  - a hardware clear sweep after reset, with a ready handshake and error flagging.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_rd_pipe.sv | 37 +++
 rtl/onchip_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_onchip_mem_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the on-chip memory controller.
package mem_pkg;

  // Controller states: clear sweep after reset, then normal service.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

  localparam int BYTE_W = 8;

  // Number of byte lanes in a data word.
  function automatic int byte_count(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Bits needed to index a storage array of the given depth (at least 1).
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read return pipeline: LAT stages of {valid, data}, flushed by Reset.
// The last stage drives readout/rvalid directly.
module mem_rd_pipe #(
  parameter int LAT = 1,
  parameter int W   = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] vld;
  logic [W-1:0]   dat [LAT];

  // Shift accepted reads toward the output; data only moves with a valid
  // token, so the final stage holds the previous result between strobes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_data  = dat[LAT-1];

endmodule

// File: rtl/onchip_mem_ctrl.sv
// Single-port on-chip RAM with byte-enable writes, pipelined reads of
// configurable latency, a post-reset clear sweep and illegal-request flagging.
module onchip_mem_ctrl
  import mem_pkg::*;
#(
  parameter int              DATA_W         = 16,
  parameter int              ADDR_W         = 10,
  parameter int              DEPTH          = 256,
  parameter int              RD_LAT         = 1,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   data,
  input  logic [ADDR_W-1:0]   address,
  input  logic                rden,
  input  logic                wren,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   readout,
  output logic                rvalid,
  output logic                err
);

  localparam int NBYTES = byte_count(DATA_W);
  localparam int IDX_W  = index_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  if ((DATA_W % BYTE_W) != 0 || RD_LAT < 1 || RD_LAT > 3 ||
      DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_params
    $error("onchip_mem_ctrl: illegal parameter combination");
  end

  mem_state_t        state;
  logic [IDX_W-1:0]  clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Request decode. Range check uses every address bit; indexing uses only
  // the low bits that cover DEPTH.
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              accept;
  logic              rd_ok;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_word;

  assign idx      = address[IDX_W-1:0];
  assign in_range = ({1'b0, address} < DEPTH_LIM);
  assign accept   = ready & ~Reset;
  assign rd_ok    = accept & rden & ~wren;
  assign wr_ok    = accept & wren & ~rden & in_range;
  assign rd_word  = in_range ? mem[idx] : '0;

  // Write port mux: the clear sweep owns the port while in CLEAR.
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [NBYTES-1:0] mem_be;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_wdata = data;
    mem_be    = be;
    if (!Reset && state == CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_ptr;
      mem_wdata = CLEAR_VAL;
      mem_be    = '1;
    end else if (wr_ok) begin
      mem_we    = 1'b1;
    end
  end

  // Storage with per-byte write enables.
  // NOTE: the array is deliberately not reset; the clear sweep initialises it,
  // which keeps the storage mappable onto a RAM macro.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_be[b]) mem[mem_idx][BYTE_W*b +: BYTE_W] <= mem_wdata[BYTE_W*b +: BYTE_W];
      end
    end
  end

  // Read data is captured at the accept edge and travels RD_LAT stages.
  mem_rd_pipe #(
    .LAT (RD_LAT),
    .W   (DATA_W)
  ) u_rd_pipe (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (rd_ok),
    .in_data   (rd_word),
    .out_valid (rvalid),
    .out_data  (readout)
  );

  // Controller FSM with registered ready/err: sweep, then serve requests.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (CLEAR_ON_RESET != 0) state <= CLEAR;
      else                     state <= READY;
      clr_ptr <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          err <= 1'b0;
          if (clr_ptr == LAST_IDX) begin
            clr_ptr <= '0;
            state   <= READY;
            ready   <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
            ready   <= 1'b0;
          end
        end
        READY: begin
          ready <= 1'b1;
          err   <= accept & (rden | wren) & ((rden & wren) | ~in_range);
        end
        default: begin
          state <= READY;
          ready <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_ctrl.sv
// Randomised and directed stimulus for onchip_mem_ctrl, checked every cycle
// against a word-array reference model. Three instances share the request
// bus: RD_LAT=1, RD_LAT=3 (both with a clear sweep) and one without a sweep.
module tb_onchip_mem_ctrl;

  localparam logic [15:0] CV    = 16'hA5A5;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset, reset_nc;
  logic [15:0] data;
  logic [9:0]  address;
  logic        rden, wren;
  logic [1:0]  be;

  logic        ready1, rvalid1, err1;
  logic [15:0] readout1;
  logic        ready3, rvalid3, err3;
  logic [15:0] readout3;
  logic        ready_nc, rvalid_nc, err_nc;
  logic [15:0] readout_nc;

  always #5 clk = ~clk;

  onchip_mem_ctrl #(.DATA_W(16), .ADDR_W(10), .DEPTH(DEPTH), .RD_LAT(1),
                    .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)) dut1 (
    .Clk(clk), .Reset(reset), .data(data), .address(address), .rden(rden),
    .wren(wren), .be(be), .ready(ready1), .readout(readout1),
    .rvalid(rvalid1), .err(err1));

  onchip_mem_ctrl #(.DATA_W(16), .ADDR_W(10), .DEPTH(DEPTH), .RD_LAT(3),
                    .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)) dut3 (
    .Clk(clk), .Reset(reset), .data(data), .address(address), .rden(rden),
    .wren(wren), .be(be), .ready(ready3), .readout(readout3),
    .rvalid(rvalid3), .err(err3));

  onchip_mem_ctrl #(.DATA_W(16), .ADDR_W(10), .DEPTH(DEPTH), .RD_LAT(1),
                    .CLEAR_ON_RESET(0), .CLEAR_VAL(CV)) dut_nc (
    .Clk(clk), .Reset(reset_nc), .data(data), .address(address), .rden(rden),
    .wren(wren), .be(be), .ready(ready_nc), .readout(readout_nc),
    .rvalid(rvalid_nc), .err(err_nc));

  // Reference model state
  logic [15:0] ref_mem [DEPTH];
  bit          m_ready;
  int          since_rst;
  int          cyc;
  bit          ev1 [8];
  bit          ev3 [8];
  bit          eerr [8];
  logic [15:0] ed1 [8];
  logic [15:0] ed3 [8];
  logic [15:0] exp_rd1, exp_rd3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive the request, update the model at the edge, check at the
  // following negedge. Slot s holds what is due in the cycle after edge cyc.
  task automatic tick(input bit rst, input bit r, input bit w,
                      input logic [9:0] a, input logic [15:0] d, input logic [1:0] b);
    int s;
    int s3;
    logic [15:0] rd;
    reset   = rst;
    rden    = r;
    wren    = w;
    address = a;
    data    = d;
    be      = b;
    @(posedge clk);
    cyc++;
    s  = cyc % 8;
    s3 = (cyc + 2) % 8;
    if (rst) begin
      since_rst = 0;
      m_ready   = 1'b0;
      for (int i = 0; i < 8; i++) begin
        ev1[i] = 1'b0; ev3[i] = 1'b0; eerr[i] = 1'b0;
      end
      exp_rd1 = '0;
      exp_rd3 = '0;
    end else begin
      if (m_ready) begin
        if (r && w) begin
          eerr[s] = 1'b1;
        end else if (r) begin
          rd = (a < DEPTH) ? ref_mem[a[7:0]] : 16'h0000;
          ev1[s]  = 1'b1; ed1[s]  = rd;
          ev3[s3] = 1'b1; ed3[s3] = rd;
          if (a >= DEPTH) eerr[s] = 1'b1;
        end else if (w) begin
          if (a < DEPTH) begin
            if (b[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
            if (b[1]) ref_mem[a[7:0]][15:8] = d[15:8];
          end else begin
            eerr[s] = 1'b1;
          end
        end
      end
      if (since_rst < 1000) since_rst++;
      if (since_rst == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = CV;
      end
      m_ready = (since_rst >= DEPTH);
    end
    @(negedge clk);
    if (ev1[s]) exp_rd1 = ed1[s];
    if (ev3[s]) exp_rd3 = ed3[s];
    check("ready1",   ready1,   m_ready);
    check("ready3",   ready3,   m_ready);
    check("rvalid1",  rvalid1,  ev1[s]);
    check("rvalid3",  rvalid3,  ev3[s]);
    check("readout1", readout1, exp_rd1);
    check("readout3", readout3, exp_rd3);
    check("err1",     err1,     eerr[s]);
    check("err3",     err3,     eerr[s]);
    ev1[s]  = 1'b0;
    ev3[s]  = 1'b0;
    eerr[s] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 10'd0, 16'h0, 2'b00);
  endtask

  // Random request: mostly reads/writes, some conflicts, some out of range,
  // with a bias toward a few addresses so read-after-write is exercised.
  task automatic rnd_tick();
    int op;
    logic [9:0] a;
    op = $urandom_range(0, 9);
    if ($urandom_range(0, 9) == 0)      a = 10'($urandom_range(256, 1023));
    else if ($urandom_range(0, 1) == 1) a = 10'($urandom_range(0, 15));
    else                                a = 10'($urandom_range(0, 255));
    tick(1'b0, (op < 4) || (op == 8), (op >= 4 && op < 8) || (op == 8),
         a, 16'($urandom), 2'($urandom));
  endtask

  initial begin
    reset    = 1'b1;
    reset_nc = 1'b1;
    rden     = 1'b0;
    wren     = 1'b0;
    address  = '0;
    data     = '0;
    be       = '0;
    cyc      = 0;
    since_rst = 0;
    m_ready  = 1'b0;
    exp_rd1  = '0;
    exp_rd3  = '0;

    // Sweep interrupted at cycle 100 by a second reset; requests are ignored.
    tick(1'b1, 1'b0, 1'b0, 10'd0, 16'h0, 2'b00);
    for (int i = 0; i < 100; i++) rnd_tick();
    tick(1'b1, 1'b0, 1'b0, 10'd0, 16'h0, 2'b00);
    for (int i = 0; i < DEPTH; i++) rnd_tick();

    // Cleared contents at both ends and the middle.
    tick(1'b0, 1'b1, 1'b0, 10'd0,   16'h0, 2'b00);
    tick(1'b0, 1'b1, 1'b0, 10'd128, 16'h0, 2'b00);
    tick(1'b0, 1'b1, 1'b0, 10'd255, 16'h0, 2'b00);
    idle(3);

    // Byte-enable merge followed by a read.
    tick(1'b0, 1'b0, 1'b1, 10'd5, 16'h1234, 2'b11);
    tick(1'b0, 1'b0, 1'b1, 10'd5, 16'hFF99, 2'b10);
    tick(1'b0, 1'b1, 1'b0, 10'd5, 16'h0000, 2'b00);
    idle(3);

    // Back-to-back pipelined reads.
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1, 10'(i), 16'(i + 100), 2'b11);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, 10'(i), 16'h0, 2'b00);
    idle(3);

    // Conflict, out-of-range read and write, aliasing address untouched.
    tick(1'b0, 1'b0, 1'b1, 10'd3,   16'h0042, 2'b11);
    tick(1'b0, 1'b1, 1'b1, 10'd3,   16'h9999, 2'b11);
    tick(1'b0, 1'b1, 1'b0, 10'd3,   16'h0000, 2'b00);
    tick(1'b0, 1'b1, 1'b0, 10'd300, 16'h0000, 2'b00);
    tick(1'b0, 1'b0, 1'b1, 10'd300, 16'hDEAD, 2'b11);
    tick(1'b0, 1'b1, 1'b0, 10'd44,  16'h0000, 2'b00);
    idle(3);

    // Reset with reads in flight: pending RD_LAT=3 results are discarded.
    tick(1'b0, 1'b1, 1'b0, 10'd10, 16'h0, 2'b00);
    tick(1'b0, 1'b1, 1'b0, 10'd11, 16'h0, 2'b00);
    tick(1'b1, 1'b1, 1'b0, 10'd12, 16'h0, 2'b00);
    for (int i = 0; i < DEPTH; i++) rnd_tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) rnd_tick();
    idle(3);

    // Instance without a sweep: held in reset so far.
    check("nc_ready_in_reset", ready_nc, 1'b0);
    reset_nc = 1'b0;
    idle(1);
    check("nc_ready_after_reset", ready_nc, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 10'd1, 16'hBEEF, 2'b11);
    tick(1'b0, 1'b1, 1'b0, 10'd1, 16'h0000, 2'b00);
    check("nc_rvalid", rvalid_nc, 1'b1);
    check("nc_readout", readout_nc, 16'hBEEF);
    idle(1);
    check("nc_rvalid_pulse", rvalid_nc, 1'b0);
    check("nc_readout_hold", readout_nc, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
